// File: rtl/pc_if.sv
// Fetch-address bus between the IF stage controller and the program counter.
// Parameter: size - datapath width in bits.
// Signals:
//   MPC     - PC-relative redirect select (next PC = PC + IMM)
//   JALR    - register-relative redirect select (next PC = IMM_rs, bit 0 cleared)
//   IMM     - signed PC-relative offset
//   IMM_rs  - precomputed rs1+imm JALR target
//   PC_Addr - current fetch address (registered)
//   PC_save - return address, PC_Addr + 4
// Modports: master drives selects/data, slave (the PC) drives addresses.
interface pc_if #(
  parameter int size = 32
);
  logic            MPC;
  logic            JALR;
  logic [size-1:0] IMM;
  logic [size-1:0] IMM_rs;
  logic [size-1:0] PC_Addr;
  logic [size-1:0] PC_save;

  modport master (
    output MPC, JALR, IMM, IMM_rs,
    input  PC_Addr, PC_save
  );

  modport slave (
    input  MPC, JALR, IMM, IMM_rs,
    output PC_Addr, PC_save
  );
endinterface

// File: rtl/pc.sv
// Program counter for the IF stage of the 5-stage RV32I pipeline.
// Holds the fetch address and picks the next one each cycle:
//   JALR -> {IMM_rs[size-1:1], 0}, else MPC -> PC + IMM, else PC + 4.
// All adders are size bits wide; carry-out is dropped so the PC wraps.
// Ports:
//   clk   - clock, state updates on the rising edge
//   reset - synchronous active-low reset, loads RESET_ADDR
//   bus   - pc_if slave: MPC/JALR/IMM/IMM_rs in, PC_Addr/PC_save out
// Build option: define PC_WORD_ALIGN_EN to force bits [1:0] of every
// next-PC value to zero, so the PC is always word aligned.
module pc #(
  parameter int              size       = 32,
  parameter logic [size-1:0] RESET_ADDR = '0
) (
  input  logic  clk,
  input  logic  reset,
  pc_if.slave   bus
);

  localparam logic [size-1:0] STEP = size'(32'd4);

  logic [size-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q + STEP;
    if (bus.JALR)     pc_d = {bus.IMM_rs[size-1:1], 1'b0};
    else if (bus.MPC) pc_d = pc_q + bus.IMM;
`ifdef PC_WORD_ALIGN_EN
    pc_d[1:0] = 2'b00;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_ADDR;
    else        pc_q <= pc_d;
  end

  assign bus.PC_Addr = pc_q;
  // Link address follows the register only; the redirect selects never reach it.
  assign bus.PC_save = pc_q + STEP;

endmodule

// File: tb/tb_pc.sv
module tb_pc;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pc_if #(.size(32)) bus ();

  pc #(.size(32), .RESET_ADDR(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef PC_WORD_ALIGN_EN
  localparam logic [31:0] E_IMM6   = 32'd4;
  localparam logic [31:0] E_RS103  = 32'd100;
  localparam logic [31:0] E_SEQ    = 32'd104;
  localparam logic [31:0] E_RS102  = 32'd100;
`else
  localparam logic [31:0] E_IMM6   = 32'd6;
  localparam logic [31:0] E_RS103  = 32'd102;
  localparam logic [31:0] E_SEQ    = 32'd106;
  localparam logic [31:0] E_RS102  = 32'd102;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check address and link address.
  task automatic step(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_save);
    @(posedge clk);
    #1;
    chk({tag, ".addr"}, bus.PC_Addr, exp_pc);
    chk({tag, ".save"}, bus.PC_save, exp_save);
  endtask

  task automatic drive(input logic r, input logic mpc, input logic jalr,
                       input logic [31:0] imm, input logic [31:0] rs);
    reset      = r;
    bus.MPC    = mpc;
    bus.JALR   = jalr;
    bus.IMM    = imm;
    bus.IMM_rs = rs;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset held: PC stays at RESET_ADDR.
    for (int i = 0; i < 4; i++) step("rst_hold", 32'd0, 32'd4);

    // Sequential run.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step("seq4",  32'd4,  32'd8);
    step("seq8",  32'd8,  32'd12);
    step("seq12", 32'd12, 32'd16);
    step("seq16", 32'd16, 32'd20);
    step("seq20", 32'd20, 32'd24);

    // PC-relative +12 steps.
    drive(1'b1, 1'b1, 1'b0, 32'd12, 32'd0);
    step("mpc32", 32'd32, 32'd36);
    step("mpc44", 32'd44, 32'd48);
    step("mpc56", 32'd56, 32'd60);
    step("mpc68", 32'd68, 32'd72);
    step("mpc80", 32'd80, 32'd84);

    // Reset overrides MPC mid-run, then MPC and sequential resume.
    drive(1'b0, 1'b1, 1'b0, 32'd12, 32'd0);
    step("rst_mid", 32'd0, 32'd4);
    drive(1'b1, 1'b1, 1'b0, 32'd12, 32'd0);
    step("rel_mpc", 32'd12, 32'd16);
    drive(1'b1, 1'b0, 1'b0, 32'd12, 32'd0);
    step("rel_seq", 32'd16, 32'd20);

    // JALR beats MPC.
    drive(1'b1, 1'b1, 1'b1, 32'd12, 32'd100);
    step("prio_a", 32'd100, 32'd104);
    step("prio_b", 32'd100, 32'd104);

    // JALR clears bit 0; negative offset moves backward.
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd101);
    step("jalr101", 32'd100, 32'd104);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
    step("neg8", 32'd92, 32'd96);

    // Wrap at the top of the address space (PC_save wraps too).
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
    step("top", 32'hFFFF_FFFC, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step("wrap", 32'd0, 32'd4);

    // Misaligned targets: passed through unless word alignment is built in.
    drive(1'b1, 1'b1, 1'b0, 32'd6, 32'd0);
    step("imm6", E_IMM6, E_IMM6 + 32'd4);
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd103);
    step("rs103", E_RS103, E_RS103 + 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step("seq_al", E_SEQ, E_SEQ + 32'd4);
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd102);
    step("rs102", E_RS102, E_RS102 + 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
